// File: rtl/empacota_4pra8.sv
// Packs two consecutive 4-bit BCD digits into one 8-bit score byte.
// A valid/ready handshake is used on both the nibble input and the byte output.
module empacota_4pra8 #(
    parameter int ORDEM        = 0, // 0: first nibble -> [3:0]; 1: first nibble -> [7:4]
    parameter int VERIFICA_BCD = 1  // 1: nibble codes above 9 are consumed and dropped
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       limpa,
    input  logic [3:0] nib_in,
    input  logic       nib_valid,
    output logic       nib_ready,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       erro_bcd
);

    localparam logic [1:0] ESPERA_1 = 2'd0;
    localparam logic [1:0] ESPERA_2 = 2'd1;
    localparam logic [1:0] CHEIO    = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [3:0] primeiro;
    logic [3:0] primeiro_next;
    logic [7:0] byte_next;
    logic       valid_next;
    logic       erro_next;
    logic       nib_xfer;
    logic       byte_xfer;
    logic       invalido;
    logic [7:0] empacotado;

    // The ready signal depends on the state only, so the producer never sees byte_ready ripple through.
    assign nib_ready  = (state != CHEIO);
    assign nib_xfer   = nib_valid && nib_ready;
    assign byte_xfer  = byte_valid && byte_ready;
    assign invalido   = (VERIFICA_BCD != 0) && (nib_in > 4'd9);
    assign empacotado = (ORDEM != 0) ? {primeiro, nib_in} : {nib_in, primeiro};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        state_next    = state;
        primeiro_next = primeiro;
        byte_next     = byte_out;
        valid_next    = byte_valid;
        erro_next     = 1'b0;

        if (limpa) begin
            // Clear wins over any transfer on the same edge; that transfer counts as not accepted.
            state_next    = ESPERA_1;
            primeiro_next = 4'h0;
            byte_next     = 8'h00;
            valid_next    = 1'b0;
        end else begin
            case (state)
                ESPERA_1: begin
                    if (nib_xfer) begin
                        if (invalido) begin
                            erro_next = 1'b1;
                        end else begin
                            primeiro_next = nib_in;
                            state_next    = ESPERA_2;
                        end
                    end
                end
                ESPERA_2: begin
                    if (nib_xfer) begin
                        if (invalido) begin
                            erro_next = 1'b1;
                        end else begin
                            byte_next  = empacotado;
                            valid_next = 1'b1;
                            state_next = CHEIO;
                        end
                    end
                end
                CHEIO: begin
                    // byte_out keeps its last value after the handoff until the next packing.
                    if (byte_xfer) begin
                        valid_next = 1'b0;
                        state_next = ESPERA_1;
                    end
                end
                default: begin
                    valid_next = 1'b0;
                    state_next = ESPERA_1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: every state register has a reset value, because the output byte must read 0 straight out of reset.
        if (!reset_n) begin
            state      <= ESPERA_1;
            primeiro   <= 4'h0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            erro_bcd   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values of the others.
            state      <= state_next;
            primeiro   <= primeiro_next;
            byte_out   <= byte_next;
            byte_valid <= valid_next;
            erro_bcd   <= erro_next;
        end
    end

endmodule

// File: tb/tb_empacota_4pra8.sv
// Bench for empacota_4pra8: three parameter variants and directed stimulus.
// A scoreboard queue per variant holds the expected bytes, and a negedge monitor checks each byte handoff.
module tb_empacota_4pra8;

    logic       clk;
    logic       reset_n;
    logic       limpa;
    logic [3:0] nib_in;
    logic       nib_valid;
    logic       byte_ready;
    logic [2:0] sel;

    logic [2:0] nv;
    logic [2:0] br;
    logic [2:0] nib_ready_w;
    logic [2:0] byte_valid_w;
    logic [2:0] erro_w;
    logic [7:0] bo0, bo1, bo2;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic [7:0] exp2[$];

    int tests;
    int fails;

    assign nv = {3{nib_valid}} & sel;
    assign br = {3{byte_ready}} & sel;

    // Variant 0: default parameters (ORDEM 0, BCD check on).
    empacota_4pra8 #(.ORDEM(0), .VERIFICA_BCD(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .limpa(limpa), .nib_in(nib_in),
        .nib_valid(nv[0]), .nib_ready(nib_ready_w[0]), .byte_out(bo0),
        .byte_valid(byte_valid_w[0]), .byte_ready(br[0]), .erro_bcd(erro_w[0])
    );
    // Variant 1: the first nibble goes to the high half of the byte.
    empacota_4pra8 #(.ORDEM(1), .VERIFICA_BCD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .limpa(limpa), .nib_in(nib_in),
        .nib_valid(nv[1]), .nib_ready(nib_ready_w[1]), .byte_out(bo1),
        .byte_valid(byte_valid_w[1]), .byte_ready(br[1]), .erro_bcd(erro_w[1])
    );
    // Variant 2: all 16 nibble codes are accepted.
    empacota_4pra8 #(.ORDEM(0), .VERIFICA_BCD(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .limpa(limpa), .nib_in(nib_in),
        .nib_valid(nv[2]), .nib_ready(nib_ready_w[2]), .byte_out(bo2),
        .byte_valid(byte_valid_w[2]), .byte_ready(br[2]), .erro_bcd(erro_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // A transfer on the coming posedge is visible at the negedge before it.
    always @(negedge clk) begin
        if (reset_n && !limpa) begin
            if (byte_valid_w[0] && br[0]) begin
                if (exp0.size() == 0) check("dut0_unexpected_byte", {24'h0, bo0}, 32'hFFFF_FFFF);
                else check("dut0_byte", {24'h0, bo0}, {24'h0, exp0.pop_front()});
            end
            if (byte_valid_w[1] && br[1]) begin
                if (exp1.size() == 0) check("dut1_unexpected_byte", {24'h0, bo1}, 32'hFFFF_FFFF);
                else check("dut1_byte", {24'h0, bo1}, {24'h0, exp1.pop_front()});
            end
            if (byte_valid_w[2] && br[2]) begin
                if (exp2.size() == 0) check("dut2_unexpected_byte", {24'h0, bo2}, 32'hFFFF_FFFF);
                else check("dut2_byte", {24'h0, bo2}, {24'h0, exp2.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends two nibbles back to back on the selected variant, then hands off the byte.
    task automatic pack_and_take(input logic [3:0] a, input logic [3:0] b);
        nib_valid = 1'b1;
        nib_in = a;
        tick();
        nib_in = b;
        tick();
        nib_valid = 1'b0;
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
    endtask

    initial begin
        int idx;
        int cycles;
        logic rdy;
        logic [3:0] digits [10];

        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        limpa = 1'b0;
        nib_in = 4'h0;
        nib_valid = 1'b0;
        byte_ready = 1'b0;
        sel = 3'b001;

        #3;
        check("reset_byte_valid", {31'h0, byte_valid_w[0]}, 32'h0);
        check("reset_byte_out", {24'h0, bo0}, 32'h00);
        check("reset_nib_ready", {31'h0, nib_ready_w[0]}, 32'h1);
        check("reset_erro", {31'h0, erro_w[0]}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;

        // Basic pack 7 then 3, held in CHEIO under backpressure.
        exp0.push_back(8'h37);
        nib_valid = 1'b1;
        nib_in = 4'h7;
        tick();
        check("after_first_nib_ready", {31'h0, nib_ready_w[0]}, 32'h1);
        check("after_first_valid", {31'h0, byte_valid_w[0]}, 32'h0);
        nib_in = 4'h3;
        tick();
        check("cheio_nib_ready", {31'h0, nib_ready_w[0]}, 32'h0);
        check("cheio_byte_valid", {31'h0, byte_valid_w[0]}, 32'h1);
        check("cheio_byte_out", {24'h0, bo0}, 32'h37);
        nib_in = 4'h5;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_byte_out", {24'h0, bo0}, 32'h37);
            check("bp_nib_ready", {31'h0, nib_ready_w[0]}, 32'h0);
            check("bp_byte_valid", {31'h0, byte_valid_w[0]}, 32'h1);
        end
        nib_valid = 1'b0;
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        check("taken_byte_valid", {31'h0, byte_valid_w[0]}, 32'h0);
        check("taken_nib_ready", {31'h0, nib_ready_w[0]}, 32'h1);
        check("taken_byte_out_kept", {24'h0, bo0}, 32'h37);

        // Invalid BCD in ESPERA_2: 2, C (dropped), 9 -> 0x92.
        exp0.push_back(8'h92);
        nib_valid = 1'b1;
        nib_in = 4'h2;
        tick();
        check("pre_err_erro", {31'h0, erro_w[0]}, 32'h0);
        nib_in = 4'hC;
        tick();
        check("bad_c_erro", {31'h0, erro_w[0]}, 32'h1);
        check("bad_c_still_ready", {31'h0, nib_ready_w[0]}, 32'h1);
        nib_in = 4'h9;
        tick();
        check("nine_erro_clear", {31'h0, erro_w[0]}, 32'h0);
        check("nine_byte_valid", {31'h0, byte_valid_w[0]}, 32'h1);
        nib_valid = 1'b0;
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;

        // Back-to-back invalid nibbles in ESPERA_1 give back-to-back pulses.
        nib_valid = 1'b1;
        nib_in = 4'hA;
        tick();
        check("bad_a_erro", {31'h0, erro_w[0]}, 32'h1);
        nib_in = 4'hF;
        tick();
        check("bad_f_erro", {31'h0, erro_w[0]}, 32'h1);
        check("bad_f_no_state", {31'h0, nib_ready_w[0]}, 32'h1);
        nib_valid = 1'b0;
        tick();
        check("erro_drops", {31'h0, erro_w[0]}, 32'h0);

        // No BCD check: the same 2, C stimulus packs to 0xC2.
        sel = 3'b100;
        exp2.push_back(8'hC2);
        nib_valid = 1'b1;
        nib_in = 4'h2;
        tick();
        nib_in = 4'hC;
        tick();
        check("nobcd_erro", {31'h0, erro_w[2]}, 32'h0);
        check("nobcd_valid", {31'h0, byte_valid_w[2]}, 32'h1);
        nib_valid = 1'b0;
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;

        // ORDEM 1: 4 then 8 -> 0x48.
        sel = 3'b010;
        exp1.push_back(8'h48);
        pack_and_take(4'h4, 4'h8);
        check("ordem1_taken", {31'h0, byte_valid_w[1]}, 32'h0);

        // limpa in ESPERA_2 alongside a nibble transfer, followed by 2, 3 -> 0x32.
        sel = 3'b001;
        nib_valid = 1'b1;
        nib_in = 4'h6;
        tick();
        limpa = 1'b1;
        nib_in = 4'h1;
        tick();
        limpa = 1'b0;
        nib_valid = 1'b0;
        check("limpa_byte_out", {24'h0, bo0}, 32'h00);
        check("limpa_byte_valid", {31'h0, byte_valid_w[0]}, 32'h0);
        check("limpa_nib_ready", {31'h0, nib_ready_w[0]}, 32'h1);
        exp0.push_back(8'h32);
        pack_and_take(4'h2, 4'h3);

        // Async reset while a byte is held: clears outputs without a clock edge.
        nib_valid = 1'b1;
        nib_in = 4'h5;
        tick();
        nib_in = 4'h4;
        tick();
        nib_valid = 1'b0;
        check("pre_rst_valid", {31'h0, byte_valid_w[0]}, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, byte_valid_w[0]}, 32'h0);
        check("async_rst_byte_out", {24'h0, bo0}, 32'h00);
        check("async_rst_nib_ready", {31'h0, nib_ready_w[0]}, 32'h1);
        tick();
        reset_n = 1'b1;

        // Reset in ESPERA_2 loses the partial nibble: 8, reset, 7, 6 -> 0x67.
        nib_valid = 1'b1;
        nib_in = 4'h8;
        tick();
        nib_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        nib_valid = 1'b1;
        nib_in = 4'h7;
        tick();
        check("mid_rst_no_byte", {31'h0, byte_valid_w[0]}, 32'h0);
        exp0.push_back(8'h67);
        nib_in = 4'h6;
        tick();
        nib_valid = 1'b0;
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;

        // Full throughput: digits 0..9 under continuous valid/ready take 15 cycles.
        digits = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        exp0.push_back(8'h10);
        exp0.push_back(8'h32);
        exp0.push_back(8'h54);
        exp0.push_back(8'h76);
        exp0.push_back(8'h98);
        idx = 0;
        cycles = 0;
        byte_ready = 1'b1;
        nib_valid = 1'b1;
        while (idx < 10 && cycles < 100) begin
            nib_in = digits[idx];
            rdy = nib_ready_w[0];
            tick();
            cycles++;
            if (rdy) idx++;
            check("stream_erro", {31'h0, erro_w[0]}, 32'h0);
        end
        nib_valid = 1'b0;
        tick();
        cycles++;
        byte_ready = 1'b0;
        check("stream_cycles", cycles, 32'd15);
        tick();

        check("q0_drained", exp0.size(), 32'd0);
        check("q1_drained", exp1.size(), 32'd0);
        check("q2_drained", exp2.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
